lcd_timing_gen: RTL
===================

# lcd_timing_gen

Parametrised RGB565 LCD timing and pixel generator; successor to the fixed 480x272 timing block between the 9 MHz pixel PLL and the panel pins. Generates DE/HSYNC/VSYNC from configurable porch/sync parameters with selectable sync polarity. Exports the current pixel coordinate so an upstream frame source can supply pixel data. Optionally overlays built-in test patterns, selected at runtime and switched only on frame boundaries.

## Interface
- H_ACTIVE, 480, visible pixels per line
- H_FP, 2, horizontal front porch (clocks)
- H_SYNC, 41, HSYNC pulse width (clocks)
- H_BP, 2, horizontal back porch (clocks)
- V_ACTIVE, 272, visible lines per frame
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 10, VSYNC pulse width (lines)
- V_BP, 2, vertical back porch (lines)
- HS_POL, 0, HSYNC active level (0 = active-low)
- VS_POL, 0, VSYNC active level (0 = active-low)
- CNT_W, 11, width of h/v counters and pixel coordinates
- PixelClk  in  1  pixel clock; all logic on rising edge
- nRST  in  1  synchronous active-low reset
- mode  in  2  pattern select: 0 pass-through, 1 colour bars, 2 grid, 3 gradient
- in_r/in_g/in_b  in  5/6/5  upstream pixel for coordinate on pix_x/pix_y
- pix_x/pix_y  out  CNT_W  current counter values (registered)
- frame_start  out  1  one-cycle pulse when h=0, v=0
- LCD_DE  out  1  data enable, active high
- LCD_HSYNC/LCD_VSYNC  out  1  syncs, polarity per HS_POL/VS_POL
- LCD_R/LCD_G/LCD_B  out  5/6/5  pixel data

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (525); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (286).
- h counter 0..H_TOTAL-1, wraps to 0; v increments on h wrap, wraps 0 after V_TOTAL-1.
- Line order: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, +H_SYNC), back porch. Same order vertically, in lines.
- DE = h<H_ACTIVE && v<V_ACTIVE. HSYNC asserted during h sync region on every line, including vertical blanking. VSYNC asserted for whole lines in v sync region, edges aligned with h=0.
- mode sampled into mode_q only when h=0,v=0; mid-frame changes ignored until next frame.
- mode_q 0: RGB = in_r/g/b. 1: eight bars of BAR_W = H_ACTIVE/8 pixels: white, yellow, cyan, green, magenta, red, blue, black; bar index from a counter reset at h=0, advanced every BAR_W pixels (no divider); remainder pixels past 8*BAR_W are black. 2: white if x[3:0]==0 or y[3:0]==0, else black. 3: R=x[7:3], G=y[7:2], B=x[8:4] ^ y[8:4].
- RGB forced to 0 whenever DE is 0.
- Reset: h=v=0, pix_x=pix_y=0, mode_q=0, LCD_DE=0, LCD_HSYNC=~HS_POL, LCD_VSYNC=~VS_POL, RGB=0, frame_start=0. Reset mid-frame restarts at h=v=0 on the cycle after nRST releases; no partial sync pulse stretched.

## Timing
- pix_x/pix_y valid cycle n; in_r/g/b sampled cycle n; LCD_* for that coordinate appear cycle n+1 (single register stage). DE, syncs and RGB mutually aligned.
- frame_start high in cycle n when pix_x=0, pix_y=0; LCD_DE for pixel (0,0) rises in cycle n+1.
- Line period H_TOTAL clocks; frame period H_TOTAL*V_TOTAL clocks (150150; 59.94 Hz at 9 MHz).
- First frame after reset has full, correct timing.

## Configuration
- LCD_TESTPAT_EN defined: pattern logic present; mode behaves as above.
- Undefined: pattern logic removed; mode port present but ignored; RGB always pass-through (gated by DE).

## Test plan
- Hold nRST=0 ten cycles -> all outputs at reset values (HSYNC=VSYNC=1 with default polarity, DE=0, RGB=0).
- Free run default params -> HSYNC low 41 clocks every 525; DE high 480 clocks per active line; VSYNC low 10 lines (5250 clocks); 272 DE lines per frame.
- mode=0, in_r/g/b = {x[4:0], y[5:0], 5'h1F} -> LCD pixel one cycle after pix_x matches; RGB=0 in blanking.
- mode=1 (LCD_TESTPAT_EN) -> x=0: 31/63/31; x=60: 31/63/0; x=420..479: 0/0/0.
- Change mode 1->2 at v=100 -> remainder of frame stays bars; grid from next frame_start.
- Drop nRST at v=150,h=300 for 1 cycle -> next cycle reset values; frame_start one cycle after release; subsequent frame period exactly 150150.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// RGB565 LCD timing/pixel generator: DE/HSYNC/VSYNC from porch parameters, one output register stage.
// Define LCD_TESTPAT_EN to build the runtime-selectable test-pattern overlay (bars, grid, gradient).
module lcd_timing_gen #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 11
) (
    input  logic             PixelClk,
    input  logic             nRST,
    input  logic [1:0]       mode,
    input  logic [4:0]       in_r,
    input  logic [5:0]       in_g,
    input  logic [4:0]       in_b,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_start,
    output logic             LCD_DE,
    output logic             LCD_HSYNC,
    output logic             LCD_VSYNC,
    output logic [4:0]       LCD_R,
    output logic [5:0]       LCD_G,
    output logic [4:0]       LCD_B
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] h_q, v_q, h_nxt, v_nxt;
    logic             run_q;
    logic             fs_q;
    logic             de, hs_act, vs_act;
    logic [15:0]      pat_rgb;

    // run_q is low for one cycle after reset so (0,0) is held and flagged by frame_start.
    always_comb begin
        h_nxt = h_q;
        v_nxt = v_q;
        if (run_q) begin
            if (h_q == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_q == V_LAST) ? '0 : v_q + CNT_ONE;
            end else begin
                h_nxt = h_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge PixelClk) begin
        if (!nRST) begin
            h_q   <= '0;
            v_q   <= '0;
            run_q <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            h_q   <= h_nxt;
            v_q   <= v_nxt;
            run_q <= 1'b1;
            fs_q  <= (h_nxt == '0) && (v_nxt == '0);
        end
    end

    assign pix_x       = h_q;
    assign pix_y       = v_q;
    assign frame_start = fs_q;

    assign de     = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_act = (h_q >= HS_START) && (h_q < HS_END);
    assign vs_act = (v_q >= VS_START) && (v_q < VS_END);

`ifdef LCD_TESTPAT_EN
    localparam int               BAR_W    = H_ACTIVE / 8;
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

    logic [1:0]       mode_q, mode_eff;
    logic [CNT_W-1:0] bar_cnt_q;
    logic [3:0]       bar_idx_q;
    logic [15:0]      bar_rgb;

    // The frame_start cycle already shows pixel (0,0), so it uses the freshly sampled mode.
    assign mode_eff = fs_q ? mode : mode_q;

    // Bar index tracks h in lockstep; index 8 is the black remainder past the eighth bar.
    always_ff @(posedge PixelClk) begin
        if (!nRST) begin
            mode_q    <= 2'd0;
            bar_cnt_q <= '0;
            bar_idx_q <= 4'd0;
        end else begin
            if (fs_q) begin
                mode_q <= mode;
            end
            if (h_nxt == '0) begin
                bar_cnt_q <= '0;
                bar_idx_q <= 4'd0;
            end else if (bar_cnt_q == BAR_LAST) begin
                bar_cnt_q <= '0;
                bar_idx_q <= (bar_idx_q == 4'd8) ? 4'd8 : bar_idx_q + 4'd1;
            end else begin
                bar_cnt_q <= bar_cnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        bar_rgb = 16'h0000;
        case (bar_idx_q)
            4'd0:    bar_rgb = 16'hFFFF;
            4'd1:    bar_rgb = 16'hFFE0;
            4'd2:    bar_rgb = 16'h07FF;
            4'd3:    bar_rgb = 16'h07E0;
            4'd4:    bar_rgb = 16'hF81F;
            4'd5:    bar_rgb = 16'hF800;
            4'd6:    bar_rgb = 16'h001F;
            default: bar_rgb = 16'h0000;
        endcase
    end

    always_comb begin
        pat_rgb = {in_r, in_g, in_b};
        case (mode_eff)
            2'd1:    pat_rgb = bar_rgb;
            2'd2:    pat_rgb = ((h_q[3:0] == 4'd0) || (v_q[3:0] == 4'd0)) ? 16'hFFFF : 16'h0000;
            2'd3:    pat_rgb = {h_q[7:3], v_q[7:2], h_q[8:4] ^ v_q[8:4]};
            default: pat_rgb = {in_r, in_g, in_b};
        endcase
    end
`else
    logic unused_mode;
    assign unused_mode = ^mode;
    assign pat_rgb     = {in_r, in_g, in_b};
`endif

    always_ff @(posedge PixelClk) begin
        if (!nRST || !run_q) begin
            LCD_DE    <= 1'b0;
            LCD_HSYNC <= ~HS_POL;
            LCD_VSYNC <= ~VS_POL;
            LCD_R     <= 5'd0;
            LCD_G     <= 6'd0;
            LCD_B     <= 5'd0;
        end else begin
            LCD_DE                <= de;
            LCD_HSYNC             <= hs_act ? HS_POL : ~HS_POL;
            LCD_VSYNC             <= vs_act ? VS_POL : ~VS_POL;
            {LCD_R, LCD_G, LCD_B} <= de ? pat_rgb : 16'h0000;
        end
    end

endmodule
